// File: rtl/cursor_pkg.sv
// Shared types and helpers for the cursor controller: direction/state encodings.
// Pure declarations; no logic, no latency.
package cursor_pkg;

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic [1:0] {IDLE, HOLD, SEL_WAIT} state_t;

    localparam int GRID_BITS_DEFAULT = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cursor_controller_repeat_timer.sv
// Auto-repeat down-counter: load wins over decrement, count parks at zero until reloaded.
// expire_o is combinational from the count, so the step happens on the same edge that reloads.
module repeat_timer
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             enable_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cursor_controller.sv
// Cursor sequencer: edge-detected button steps with auto-repeat and a select req/ack handshake.
// Define CURSOR_WRAP_AROUND_EN to wrap at the grid edge instead of clamping and flagging blocked.
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int GRID_BITS    = GRID_BITS_DEFAULT,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 btn_up_i,
    input  logic                 btn_down_i,
    input  logic                 btn_left_i,
    input  logic                 btn_right_i,
    input  logic                 btn_sel_i,
    input  logic                 sel_ack_i,
    output logic [GRID_BITS-1:0] row_o,
    output logic [GRID_BITS-1:0] col_o,
    output logic                 move_pulse_o,
    output logic                 blocked_o,
    output logic                 sel_req_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE)) + 1;
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    state_t               state_q, state_d;
    dir_t                 dir_q, dir_d;
    dir_t                 rise_dir, step_dir;
    logic [4:0]           btn, btn_q, rise;
    logic                 arm_q;
    logic                 held;
    logic                 timer_load, timer_en, timer_expire;
    logic [CNT_W-1:0]     timer_val;
    logic [GRID_BITS-1:0] row_q, col_q, row_s, col_s;
    logic                 at_edge, do_move, do_block;
    logic                 move_pulse_q, blocked_q;

    // Bit order {sel, right, left, down, up}. Rises are masked on the first cycle out of
    // reset so a button already held through reset is absorbed rather than acted on.
    assign btn  = {btn_sel_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};
    assign rise = btn & ~btn_q & {5{arm_q}};

    always_comb begin
        rise_dir = DIR_NONE;
        if (rise[0])      rise_dir = DIR_UP;
        else if (rise[1]) rise_dir = DIR_DOWN;
        else if (rise[2]) rise_dir = DIR_LEFT;
        else if (rise[3]) rise_dir = DIR_RIGHT;
    end

    always_comb begin
        held = 1'b0;
        case (dir_q)
            DIR_UP:    held = btn_up_i;
            DIR_DOWN:  held = btn_down_i;
            DIR_LEFT:  held = btn_left_i;
            DIR_RIGHT: held = btn_right_i;
            default:   held = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rise[4])                    state_d = SEL_WAIT;
                else if (rise_dir != DIR_NONE)  state_d = HOLD;
            end
            HOLD:     if (!held)     state_d = IDLE;
            SEL_WAIT: if (sel_ack_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign timer_en = (state_q == HOLD) && held;

    always_comb begin
        busy_o     = (state_q != IDLE);
        sel_req_o  = (state_q == SEL_WAIT);
        step_dir   = DIR_NONE;
        timer_load = 1'b0;
        timer_val  = DELAY_LD;
        dir_d      = dir_q;
        case (state_q)
            IDLE: begin
                if (!rise[4] && (rise_dir != DIR_NONE)) begin
                    step_dir   = rise_dir;
                    timer_load = 1'b1;
                    dir_d      = rise_dir;
                end
            end
            HOLD: begin
                if (timer_expire) begin
                    step_dir   = dir_q;
                    timer_load = 1'b1;
                    timer_val  = RATE_LD;
                end
            end
            default: ;
        endcase
    end

    repeat_timer #(
        .CNT_W (CNT_W)
    ) u_repeat_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (timer_load),
        .load_value_i (timer_val),
        .enable_i     (timer_en),
        .expire_o     (timer_expire)
    );

    always_comb begin
        row_s   = row_q;
        col_s   = col_q;
        at_edge = 1'b0;
        case (step_dir)
            DIR_UP:    begin row_s = row_q - 1'b1; at_edge = (row_q == '0); end
            DIR_DOWN:  begin row_s = row_q + 1'b1; at_edge = (row_q == '1); end
            DIR_LEFT:  begin col_s = col_q - 1'b1; at_edge = (col_q == '0); end
            DIR_RIGHT: begin col_s = col_q + 1'b1; at_edge = (col_q == '1); end
            default:   ;
        endcase
    end

`ifdef CURSOR_WRAP_AROUND_EN
    // Natural modulo arithmetic of the coordinate width provides the wrap.
    assign do_move  = (step_dir != DIR_NONE);
    assign do_block = 1'b0;
`else
    assign do_move  = (step_dir != DIR_NONE) && !at_edge;
    assign do_block = (step_dir != DIR_NONE) && at_edge;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_q        <= '0;
            arm_q        <= 1'b0;
            dir_q        <= DIR_NONE;
            row_q        <= '0;
            col_q        <= '0;
            move_pulse_q <= 1'b0;
            blocked_q    <= 1'b0;
        end else begin
            btn_q        <= btn;
            arm_q        <= 1'b1;
            dir_q        <= dir_d;
            move_pulse_q <= do_move;
            blocked_q    <= do_block;
            if (do_move) begin
                row_q <= row_s;
                col_q <= col_s;
            end
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign move_pulse_o = move_pulse_q;
    assign blocked_o    = blocked_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with a short repeat profile (delay 4, rate 2).
module tb_cursor_controller;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       btn_up_i = 1'b0, btn_down_i = 1'b0, btn_left_i = 1'b0, btn_right_i = 1'b0;
    logic       btn_sel_i = 1'b0, sel_ack_i = 1'b0;
    logic [2:0] row_o, col_o;
    logic       move_pulse_o, blocked_o, sel_req_o, busy_o;

    int nchk = 0;
    int nfail = 0;

    cursor_controller #(
        .GRID_BITS    (3),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .btn_up_i     (btn_up_i),
        .btn_down_i   (btn_down_i),
        .btn_left_i   (btn_left_i),
        .btn_right_i  (btn_right_i),
        .btn_sel_i    (btn_sel_i),
        .sel_ack_i    (sel_ack_i),
        .row_o        (row_o),
        .col_o        (col_o),
        .move_pulse_o (move_pulse_o),
        .blocked_o    (blocked_o),
        .sel_req_o    (sel_req_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle press of a direction: 0=up 1=down 2=left 3=right.
    task automatic press(input int d);
        case (d)
            0: btn_up_i = 1'b1;
            1: btn_down_i = 1'b1;
            2: btn_left_i = 1'b1;
            default: btn_right_i = 1'b1;
        endcase
        tick();
        btn_up_i = 1'b0; btn_down_i = 1'b0; btn_left_i = 1'b0; btn_right_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #3;
        nchk++; if (row_o !== 3'd0) begin nfail++; $display("FAIL reset_row: got %0d want 0", row_o); end
        nchk++; if (col_o !== 3'd0) begin nfail++; $display("FAIL reset_col: got %0d want 0", col_o); end
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL reset_move: got %b want 0", move_pulse_o); end
        nchk++; if (blocked_o !== 1'b0) begin nfail++; $display("FAIL reset_blocked: got %b want 0", blocked_o); end
        nchk++; if (sel_req_o !== 1'b0) begin nfail++; $display("FAIL reset_selreq: got %b want 0", sel_req_o); end
        nchk++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single_step();
        btn_right_i = 1'b1;
        tick();
        nchk++; if (col_o !== 3'd1) begin nfail++; $display("FAIL step_col: got %0d want 1", col_o); end
        nchk++; if (move_pulse_o !== 1'b1) begin nfail++; $display("FAIL step_move: got %b want 1", move_pulse_o); end
        nchk++; if (busy_o !== 1'b1) begin nfail++; $display("FAIL step_busy: got %b want 1", busy_o); end
        btn_right_i = 1'b0;
        tick();
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL step_move_end: got %b want 0", move_pulse_o); end
        nchk++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL step_busy_end: got %b want 0", busy_o); end
        nchk++; if (col_o !== 3'd1) begin nfail++; $display("FAIL step_col_hold: got %0d want 1", col_o); end
    endtask

    task automatic test_edge();
        btn_up_i = 1'b1;
        tick();
`ifdef CURSOR_WRAP_AROUND_EN
        nchk++; if (row_o !== 3'd7) begin nfail++; $display("FAIL edge_row: got %0d want 7", row_o); end
        nchk++; if (move_pulse_o !== 1'b1) begin nfail++; $display("FAIL edge_move: got %b want 1", move_pulse_o); end
        nchk++; if (blocked_o !== 1'b0) begin nfail++; $display("FAIL edge_blocked: got %b want 0", blocked_o); end
`else
        nchk++; if (row_o !== 3'd0) begin nfail++; $display("FAIL edge_row: got %0d want 0", row_o); end
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL edge_move: got %b want 0", move_pulse_o); end
        nchk++; if (blocked_o !== 1'b1) begin nfail++; $display("FAIL edge_blocked: got %b want 1", blocked_o); end
`endif
        btn_up_i = 1'b0;
        tick();
        nchk++; if (blocked_o !== 1'b0) begin nfail++; $display("FAIL edge_blocked_end: got %b want 0", blocked_o); end
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL edge_move_end: got %b want 0", move_pulse_o); end
    endtask

    task automatic test_repeat();
        logic [2:0] exp_row [10];
        logic       exp_mp [10];
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        // Steps on the press edge, then at +4, +6, +8.
        exp_row = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
        exp_mp  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        btn_down_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            nchk++; if (row_o !== exp_row[k]) begin nfail++; $display("FAIL repeat_row[%0d]: got %0d want %0d", k, row_o, exp_row[k]); end
            nchk++; if (move_pulse_o !== exp_mp[k]) begin nfail++; $display("FAIL repeat_move[%0d]: got %b want %b", k, move_pulse_o, exp_mp[k]); end
        end
        btn_down_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            nchk++; if (row_o !== 3'd4) begin nfail++; $display("FAIL repeat_release_row[%0d]: got %0d want 4", k, row_o); end
            nchk++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL repeat_release_busy[%0d]: got %b want 0", k, busy_o); end
        end
    endtask

    task automatic test_priority();
        press(0);
        press(3); press(3); press(3);
        nchk++; if ({row_o, col_o} !== {3'd3, 3'd3}) begin nfail++; $display("FAIL prio_setup: got (%0d,%0d) want (3,3)", row_o, col_o); end
        btn_up_i = 1'b1;
        btn_right_i = 1'b1;
        tick();
        nchk++; if ({row_o, col_o} !== {3'd2, 3'd3}) begin nfail++; $display("FAIL prio_step: got (%0d,%0d) want (2,3)", row_o, col_o); end
        tick();
        tick();
        btn_up_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL prio_no_right[%0d]: got %b want 0", k, move_pulse_o); end
        end
        btn_right_i = 1'b0;
        tick();
        nchk++; if ({row_o, col_o} !== {3'd2, 3'd3}) begin nfail++; $display("FAIL prio_final: got (%0d,%0d) want (2,3)", row_o, col_o); end
    endtask

    task automatic test_select();
        press(1); press(1); press(1);
        press(2);
        nchk++; if ({row_o, col_o} !== {3'd5, 3'd2}) begin nfail++; $display("FAIL sel_setup: got (%0d,%0d) want (5,2)", row_o, col_o); end
        btn_sel_i = 1'b1;
        tick();
        nchk++; if (sel_req_o !== 1'b1) begin nfail++; $display("FAIL sel_req_rise: got %b want 1", sel_req_o); end
        nchk++; if (busy_o !== 1'b1) begin nfail++; $display("FAIL sel_busy: got %b want 1", busy_o); end
        btn_sel_i = 1'b0;
        btn_left_i = 1'b1;
        tick();
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL sel_left_move: got %b want 0", move_pulse_o); end
        nchk++; if (col_o !== 3'd2) begin nfail++; $display("FAIL sel_left_col: got %0d want 2", col_o); end
        btn_left_i = 1'b0;
        tick();
        nchk++; if (sel_req_o !== 1'b1) begin nfail++; $display("FAIL sel_req_hold: got %b want 1", sel_req_o); end
        sel_ack_i = 1'b1;
        tick();
        sel_ack_i = 1'b0;
        nchk++; if (sel_req_o !== 1'b0) begin nfail++; $display("FAIL sel_req_drop: got %b want 0", sel_req_o); end
        nchk++; if ({row_o, col_o} !== {3'd5, 3'd2}) begin nfail++; $display("FAIL sel_pos: got (%0d,%0d) want (5,2)", row_o, col_o); end
        nchk++; if (move_pulse_o !== 1'b0) begin nfail++; $display("FAIL sel_move_end: got %b want 0", move_pulse_o); end
        sel_ack_i = 1'b1;
        tick();
        sel_ack_i = 1'b0;
        nchk++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL idle_ack_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_async_reset();
        press(0);
        press(3); press(3); press(3); press(3);
        nchk++; if ({row_o, col_o} !== {3'd4, 3'd6}) begin nfail++; $display("FAIL arst_setup: got (%0d,%0d) want (4,6)", row_o, col_o); end
        btn_sel_i = 1'b1;
        tick();
        nchk++; if (sel_req_o !== 1'b1) begin nfail++; $display("FAIL arst_selreq_pre: got %b want 1", sel_req_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        nchk++; if (sel_req_o !== 1'b0) begin nfail++; $display("FAIL arst_selreq: got %b want 0", sel_req_o); end
        nchk++; if ({row_o, col_o} !== {3'd0, 3'd0}) begin nfail++; $display("FAIL arst_pos: got (%0d,%0d) want (0,0)", row_o, col_o); end
        nchk++; if (busy_o !== 1'b0) begin nfail++; $display("FAIL arst_busy: got %b want 0", busy_o); end
        tick();
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nchk++; if (sel_req_o !== 1'b0) begin nfail++; $display("FAIL arst_held_sel[%0d]: got %b want 0", k, sel_req_o); end
        end
        btn_sel_i = 1'b0;
        tick();
        btn_sel_i = 1'b1;
        tick();
        btn_sel_i = 1'b0;
        nchk++; if (sel_req_o !== 1'b1) begin nfail++; $display("FAIL arst_fresh_sel: got %b want 1", sel_req_o); end
        sel_ack_i = 1'b1;
        tick();
        sel_ack_i = 1'b0;
        nchk++; if (sel_req_o !== 1'b0) begin nfail++; $display("FAIL arst_fresh_ack: got %b want 0", sel_req_o); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_edge();
        test_repeat();
        test_priority();
        test_select();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
